buf_row_loader: RTL

//  Responder side of the controller's load-buffer handshake (ld_buf -> ld_buf_done) for one conv layer.
//  On each request it reads one picture row of ROW_LEN words from the layer's input memory into the next row
//  of a circular line buffer, then pulses ld_buf_done. init_ld rewinds it to the start of a new picture.
//  One instance per layer sits between that layer's source memory and the PE line buffer.

---
 rtl/buf_row_loader_pkg.sv | 20 ++
 rtl/buf_row_loader_mod_counter.sv | 47 ++++
 rtl/buf_row_loader.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/buf_row_loader_pkg.sv
// rtl/buf_row_loader_pkg.sv - shared state encoding and width helper for the row loader
//
// Purpose: FSM state type and index-width helper used by buf_row_loader and its counter.
// Ports: none (package).

package buf_row_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to index n entries; never less than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/buf_row_loader_mod_counter.sv
// rtl/buf_row_loader_mod_counter.sv - wrap-around modulo counter with enable and clear
//
// Purpose: counts 0..MOD-1 and wraps back to 0; clr has priority over en.
// Ports:
//   clk_i   in  1  clock, rising edge
//   rst_i   in  1  synchronous active-high reset
//   clr_i   in  1  synchronous clear to 0
//   en_i    in  1  advance by one (wrapping) this cycle
//   cnt_o   out W  current count

module buf_row_loader_mod_counter
    import buf_row_loader_pkg::*;
#(
    parameter int MOD = 4,
    parameter int W   = idx_w(MOD)
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Wrap is an explicit compare so MOD need not be a power of two.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == W'(MOD - 1)) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/buf_row_loader.sv
// rtl/buf_row_loader.sv - loads one picture row per request into a circular line buffer
//
// Purpose: responder for the ld_buf -> ld_buf_done handshake of one conv layer. Each request
//   reads ROW_LEN words from the layer memory into the next line-buffer row; init_ld rewinds
//   to the start of a new picture.
// Ports:
//   clk          in   1        clock, rising edge
//   rst          in   1        synchronous active-high reset
//   init_ld      in   1        pulse: rewind to picture start (aborts a load in progress)
//   ld_buf       in   1        pulse: load next row (ignored while busy)
//   ld_buf_done  out  1        pulse: requested row complete
//   pic_end      out  1        level: whole picture consumed
//   busy         out  1        level: load in progress
//   mem_rd_en    out  1        memory read strobe
//   mem_rd_addr  out  ADDR_W   memory read address
//   mem_rd_data  in   DATA_W   read data, one cycle after mem_rd_en
//   buf_wr_en    out  1        line-buffer write strobe
//   buf_wr_row   out  ROW_W    destination row
//   buf_wr_col   out  COL_W    destination column
//   buf_wr_data  out  DATA_W   mem_rd_data passed straight through

module buf_row_loader
    import buf_row_loader_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int ROW_LEN   = 16,
    parameter int BUF_ROWS  = 4,
    parameter int PIC_WORDS = 256,
    localparam int COL_W    = idx_w(ROW_LEN),
    localparam int ROW_W    = idx_w(BUF_ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_ld,
    input  logic              ld_buf,
    output logic              ld_buf_done,
    output logic              pic_end,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              buf_wr_en,
    output logic [ROW_W-1:0]  buf_wr_row,
    output logic [COL_W-1:0]  buf_wr_col,
    output logic [DATA_W-1:0] buf_wr_data
);

    // One extra bit so the pointer can hold PIC_WORDS itself when PIC_WORDS == 2**ADDR_W.
    localparam int PTR_W = ADDR_W + 1;

    state_t             state_q;
    logic               rd_en_q;
    logic               done_q;
    logic               wr_en_q;
    logic [COL_W-1:0]   wr_col_q;
    logic [PTR_W-1:0]   rd_ptr_q;

    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   wr_row;
    logic               col_last;
    logic               pic_end_w;
    logic               row_adv;

    assign pic_end_w = (rd_ptr_q == PTR_W'(PIC_WORDS));
    assign col_last  = (col == COL_W'(ROW_LEN - 1));
    // Only a load that actually read data moves to the next buffer row.
    assign row_adv   = (state_q == ST_DONE) && !pic_end_w;

    buf_row_loader_mod_counter #(
        .MOD (ROW_LEN),
        .W   (COL_W)
    ) u_col_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (init_ld),
        .en_i  (rd_en_q),
        .cnt_o (col)
    );

    buf_row_loader_mod_counter #(
        .MOD (BUF_ROWS),
        .W   (ROW_W)
    ) u_row_cnt (
        .clk_i (clk),
        .rst_i (rst),
        .clr_i (init_ld),
        .en_i  (row_adv),
        .cnt_o (wr_row)
    );

    // Control FSM. init_ld rewinds from any state and drops a simultaneous ld_buf.
    always_ff @(posedge clk) begin
        if (rst || init_ld) begin
            state_q  <= ST_IDLE;
            rd_en_q  <= 1'b0;
            done_q   <= 1'b0;
            rd_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ld_buf) begin
                        if (pic_end_w) begin
                            // Picture exhausted: skip the reads but keep the same
                            // DRAIN/DONE tail so the controller still gets its done.
                            state_q <= ST_DRAIN;
                        end else begin
                            state_q <= ST_READ;
                            rd_en_q <= 1'b1;
                        end
                    end
                end
                ST_READ: begin
                    if (col_last) begin
                        state_q <= ST_DRAIN;
                        rd_en_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    done_q  <= 1'b1;
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    if (!pic_end_w) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(ROW_LEN);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Write strobe and column trail the read by the one-cycle memory latency.
    always_ff @(posedge clk) begin
        if (rst || init_ld) begin
            wr_en_q  <= 1'b0;
            wr_col_q <= '0;
        end else begin
            wr_en_q  <= rd_en_q;
            wr_col_q <= col;
        end
    end

    assign ld_buf_done = done_q;
    assign pic_end     = pic_end_w;
    assign busy        = (state_q != ST_IDLE);
    assign mem_rd_en   = rd_en_q;
    assign mem_rd_addr = rd_en_q ? (rd_ptr_q[ADDR_W-1:0] + ADDR_W'(col)) : '0;
    assign buf_wr_en   = wr_en_q;
    assign buf_wr_row  = wr_row;
    assign buf_wr_col  = wr_col_q;
    assign buf_wr_data = mem_rd_data;

endmodule
